// File: rtl/iob_ethmac_mem_arbiter_pkg.sv
// rtl/iob_ethmac_mem_arbiter_pkg.sv - shared widths, port ids and address-range helper
package iob_ethmac_mem_arbiter_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MEM_ADDR_W = 13;
  localparam int DEF_ERR_CNT_W  = 16;

  // Widest IOb address the range helper accepts; callers zero-extend into it.
  localparam int OOR_MAX_ADDR_W = 64;

  typedef enum logic [0:0] {
    PORT_MAC  = 1'b0,
    PORT_HOST = 1'b1
  } port_e;

  // True when any address bit above the SRAM byte-address window is set.
  function automatic logic addr_oor(input logic [OOR_MAX_ADDR_W-1:0] addr,
                                    input int                        mem_addr_w);
    return (addr >> mem_addr_w) != '0;
  endfunction

endpackage

// File: rtl/iob_rr_arb2.sv
// rtl/iob_rr_arb2.sv - two-requester round-robin arbiter with one-hot grant
module iob_rr_arb2
  import iob_ethmac_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Reset to the host port so the MAC port wins the first tie.
  port_e last_grant;

  // Remember which port was granted most recently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_HOST;
    end else if (|req) begin
      last_grant <= gnt[1] ? PORT_HOST : PORT_MAC;
    end
  end

  // A lone requester is granted directly; a tie goes to the port not granted last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == PORT_HOST) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/iob_ethmac_mem_arbiter.sv
// rtl/iob_ethmac_mem_arbiter.sv - shares one byte-enabled SRAM between the MAC DMA and host IOb ports
module iob_ethmac_mem_arbiter
  import iob_ethmac_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  p0_valid,
  input  logic [ADDR_W-1:0]     p0_address,
  input  logic [DATA_W-1:0]     p0_wdata,
  input  logic [DATA_W/8-1:0]   p0_wstrb,
  output logic [DATA_W-1:0]     p0_rdata,
  output logic                  p0_ready,
  input  logic                  p1_valid,
  input  logic [ADDR_W-1:0]     p1_address,
  input  logic [DATA_W-1:0]     p1_wdata,
  input  logic [DATA_W/8-1:0]   p1_wstrb,
  output logic [DATA_W-1:0]     p1_rdata,
  output logic                  p1_ready,
  output logic                  mem_en_o,
  output logic [MEM_ADDR_W-3:0] mem_addr_o,
  output logic [DATA_W/8-1:0]   mem_we_o,
  output logic [DATA_W-1:0]     mem_din_o,
  input  logic [DATA_W-1:0]     mem_dout_i,
  input  logic                  clr_err_i,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
);

  localparam int STRB_W = DATA_W / 8;

  // busy is set by the grant and lasts exactly the following cycle, so it is
  // also the ready pulse of that port.
  logic [1:0] busy;
  // Marks a ready cycle whose rdata must come from the SRAM (in-range read).
  logic [1:0] rd_pend;
  logic [1:0] req;
  logic [1:0] gnt;

  logic              granted;
  logic              sel_oor;
  logic              sel_read;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  assign req = {p1_valid & ~busy[1], p0_valid & ~busy[0]};

  iob_rr_arb2 u_arb (
    .clk (clk_i),
    .rst (arst_i),
    .req (req),
    .gnt (gnt)
  );

  // Route the granted port's request fields onto the shared path.
  always_comb begin
    sel_address = p0_address;
    sel_wdata   = p0_wdata;
    sel_wstrb   = p0_wstrb;
    if (gnt[1]) begin
      sel_address = p1_address;
      sel_wdata   = p1_wdata;
      sel_wstrb   = p1_wstrb;
    end
  end

  assign granted  = |gnt;
  assign sel_oor  = addr_oor(OOR_MAX_ADDR_W'(sel_address), MEM_ADDR_W);
  assign sel_read = (sel_wstrb == '0);

  // Drive the SRAM only for a granted in-range request; otherwise keep it idle.
  always_comb begin
    mem_en_o   = 1'b0;
    mem_addr_o = '0;
    mem_we_o   = '0;
    mem_din_o  = '0;
    if (granted && !sel_oor) begin
      mem_en_o   = 1'b1;
      mem_addr_o = sel_address[MEM_ADDR_W-1:2];
      mem_we_o   = sel_wstrb;
      mem_din_o  = sel_wdata;
    end
  end

  // Register the grant into the per-port busy/ready and read-pending flags.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      busy    <= 2'b00;
      rd_pend <= 2'b00;
    end else begin
      busy    <= gnt;
      rd_pend <= gnt & {2{~sel_oor & sel_read}};
    end
  end

  // Count out-of-range grants, saturating; a clear in the same cycle wins.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      err_cnt_o <= '0;
    end else if (clr_err_i) begin
      err_cnt_o <= '0;
    end else if (granted && sel_oor && (err_cnt_o != '1)) begin
      err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

  // SRAM read data lands in the ready cycle; writes and out-of-range requests return zero.
  assign p0_ready = busy[0];
  assign p1_ready = busy[1];
  assign p0_rdata = rd_pend[0] ? mem_dout_i : '0;
  assign p1_rdata = rd_pend[1] ? mem_dout_i : '0;

endmodule

// File: tb/tb_iob_ethmac_mem_arbiter.sv
// tb/tb_iob_ethmac_mem_arbiter.sv - self-checking bench for the two-port SRAM arbiter
module tb_iob_ethmac_mem_arbiter;

  localparam int ERRW    = 2;
  localparam int ERR_MAX = (1 << ERRW) - 1;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        p0_valid, p1_valid;
  logic [31:0] p0_address, p0_wdata, p0_rdata;
  logic [31:0] p1_address, p1_wdata, p1_rdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic        p0_ready, p1_ready;
  logic        mem_en_o;
  logic [10:0] mem_addr_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_din_o, mem_dout_i;
  logic        clr_err_i;
  logic [ERRW-1:0] err_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  int errm  = 0;

  logic [31:0] sram [0:2047];
  logic [31:0] ref_mem [int];

  iob_ethmac_mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_ADDR_W (13),
    .ERR_CNT_W  (ERRW)
  ) dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .p0_valid   (p0_valid),
    .p0_address (p0_address),
    .p0_wdata   (p0_wdata),
    .p0_wstrb   (p0_wstrb),
    .p0_rdata   (p0_rdata),
    .p0_ready   (p0_ready),
    .p1_valid   (p1_valid),
    .p1_address (p1_address),
    .p1_wdata   (p1_wdata),
    .p1_wstrb   (p1_wstrb),
    .p1_rdata   (p1_rdata),
    .p1_ready   (p1_ready),
    .mem_en_o   (mem_en_o),
    .mem_addr_o (mem_addr_o),
    .mem_we_o   (mem_we_o),
    .mem_din_o  (mem_din_o),
    .mem_dout_i (mem_dout_i),
    .clr_err_i  (clr_err_i),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Single-port SRAM with byte enables and one-cycle registered read.
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_din_o[8*b +: 8];
      mem_dout_i <= sram[mem_addr_o];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int w;
    w = int'(a[12:2]);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'h0;
  endfunction

  function automatic void ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = ref_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a[12:2])] = v;
  endfunction

  // One complete transfer on an idle arbiter, checked against the reference model.
  task automatic op(input string tag, input int port, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [3:0] ws, output logic [31:0] rd);
    logic        oor, en, done;
    logic [31:0] exp_rd;
    logic [10:0] maddr;
    int          lat;
    oor    = (addr >> 13) != 0;
    exp_rd = (ws == 4'h0 && !oor) ? ref_rd(addr) : 32'h0;
    if (oor) errm = clr_err_i ? 0 : ((errm < ERR_MAX) ? errm + 1 : errm);
    if (port == 0) begin
      p0_address = addr; p0_wdata = wd; p0_wstrb = ws; p0_valid = 1'b1;
    end else begin
      p1_address = addr; p1_wdata = wd; p1_wstrb = ws; p1_valid = 1'b1;
    end
    #1;
    en    = mem_en_o;
    maddr = mem_addr_o;
    lat   = 0;
    done  = 1'b0;
    rd    = 32'h0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk_i);
      lat++;
      if ((port == 0) ? p0_ready : p1_ready) begin
        done = 1'b1;
        rd   = (port == 0) ? p0_rdata : p1_rdata;
      end
    end
    if (port == 0) p0_valid = 1'b0; else p1_valid = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'd1);
    chk({tag, "_mem_en"}, 64'(en), 64'(!oor));
    if (!oor) chk({tag, "_mem_addr"}, 64'(maddr), 64'(addr[12:2]));
    chk({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    chk({tag, "_err_cnt"}, 64'(err_cnt_o), 64'(errm));
    if (!oor && ws != 4'h0) ref_wr(addr, wd, ws);
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] rd, addr;
    logic [3:0]  ws;
    logic [1:0]  exp_rdy;
    int          port, kind, g, i0, i1;
    int          gl[$];

    for (int i = 0; i < 2048; i++) sram[i] = 32'h0;
    arst_i = 1'b1; clr_err_i = 1'b0;
    p0_valid = 1'b0; p0_address = '0; p0_wdata = '0; p0_wstrb = '0;
    p1_valid = 1'b0; p1_address = '0; p1_wdata = '0; p1_wstrb = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_p0_ready", 64'(p0_ready), 64'd0);
    chk("rst_p1_ready", 64'(p1_ready), 64'd0);
    chk("rst_p0_rdata", 64'(p0_rdata), 64'd0);
    chk("rst_p1_rdata", 64'(p1_rdata), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt_o), 64'd0);
    chk("rst_mem_en", 64'(mem_en_o), 64'd0);
    arst_i = 1'b0;
    @(negedge clk_i);

    // Full-word write then read back.
    op("w_deadbeef", 0, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    op("r_deadbeef", 0, 32'h10, 32'h0, 4'h0, rd);
    chk("deadbeef_value", 64'(rd), 64'hDEADBEEF);

    // Single-byte strobe merges into existing word.
    op("w_base", 1, 32'h20, 32'h11223344, 4'hF, rd);
    op("w_byte1", 0, 32'h20, 32'h0000AB00, 4'h2, rd);
    op("r_merge", 1, 32'h20, 32'h0, 4'h0, rd);
    chk("merge_value", 64'(rd), 64'h1122AB44);

    // Host preload of the words used by the contention test.
    for (int k = 0; k < 4; k++) begin
      op("preload0", 1, 32'h100 + 4*k, $urandom, 4'hF, rd);
      op("preload1", 1, 32'h200 + 4*k, $urandom, 4'hF, rd);
    end

    // Random mix of reads, strobed writes and out-of-range requests.
    for (int n = 0; n < 24; n++) begin
      port = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind == 0) addr = 32'h2000 | ($urandom & 32'hFFFF_E000);
      else addr = 32'h100 + 4*$urandom_range(0, 71) + $urandom_range(0, 3);
      ws = (kind < 5) ? 4'($urandom_range(1, 15)) : 4'h0;
      op("rand", port, addr, $urandom, ws, rd);
    end

    // Fresh reset, then both ports contend with back-to-back reads.
    arst_i = 1'b1;
    @(negedge clk_i);
    arst_i = 1'b0;
    errm = 0;
    chk("rst2_err_cnt", 64'(err_cnt_o), 64'd0);
    i0 = 0; i1 = 0;
    p0_address = 32'h100; p0_wstrb = 4'h0; p0_valid = 1'b1;
    p1_address = 32'h200; p1_wstrb = 4'h0; p1_valid = 1'b1;
    for (int cyc = 0; cyc < 30 && (i0 < 4 || i1 < 4); cyc++) begin
      #1;
      g = -1;
      if (mem_en_o) g = (p0_valid && mem_addr_o == p0_address[12:2]) ? 0 : 1;
      if (g >= 0) gl.push_back(g);
      @(negedge clk_i);
      exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      chk("conc_ready", 64'({p1_ready, p0_ready}), 64'(exp_rdy));
      if (p0_ready) begin
        chk("conc_rdata0", 64'(p0_rdata), 64'(ref_rd(32'h100 + 4*i0)));
        i0++;
        if (i0 < 4) p0_address = 32'h100 + 4*i0; else p0_valid = 1'b0;
      end
      if (p1_ready) begin
        chk("conc_rdata1", 64'(p1_rdata), 64'(ref_rd(32'h200 + 4*i1)));
        i1++;
        if (i1 < 4) p1_address = 32'h200 + 4*i1; else p1_valid = 1'b0;
      end
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    chk("conc_done0", 64'(i0), 64'd4);
    chk("conc_done1", 64'(i1), 64'd4);
    chk("conc_grants", 64'(gl.size()), 64'd8);
    foreach (gl[k]) chk("conc_order", 64'(gl[k]), 64'(k % 2));
    @(negedge clk_i);

    // Out-of-range read, then clear.
    op("oor_2000", 0, 32'h2000, 32'h0, 4'h0, rd);
    chk("oor_err_one", 64'(err_cnt_o), 64'd1);
    clr_err_i = 1'b1;
    @(negedge clk_i);
    clr_err_i = 1'b0;
    errm = 0;
    chk("clr_err", 64'(err_cnt_o), 64'd0);

    // Clear coinciding with an out-of-range grant.
    op("oor_pre", 1, 32'h4000, 32'h0, 4'h0, rd);
    clr_err_i = 1'b1;
    op("oor_clr", 0, 32'h8000_0000, 32'h0, 4'h0, rd);
    clr_err_i = 1'b0;
    chk("clr_wins", 64'(err_cnt_o), 64'd0);

    // Saturation over five out-of-range requests.
    for (int k = 0; k < 5; k++) op("sat", k % 2, 32'h0001_0000 + 4*k, 32'h0, 4'h0, rd);
    chk("sat_value", 64'(err_cnt_o), 64'(ERR_MAX));

    // Reset while p1's ready is pending.
    p1_address = 32'h10; p1_wstrb = 4'h0; p1_valid = 1'b1;
    @(posedge clk_i);
    #1 arst_i = 1'b1;
    #1;
    chk("arst_p1_ready", 64'(p1_ready), 64'd0);
    chk("arst_p1_rdata", 64'(p1_rdata), 64'd0);
    chk("arst_err_cnt", 64'(err_cnt_o), 64'd0);
    p1_valid = 1'b0;
    errm = 0;
    @(negedge clk_i);
    arst_i = 1'b0;
    @(negedge clk_i);
    op("post_rst_read", 1, 32'h10, 32'h0, 4'h0, rd);
    chk("post_rst_value", 64'(rd), 64'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
